// File: rtl/mipi_dsi_pkg.sv
// mipi_dsi_pkg: shared constants and helpers for the DSI receive packet parser.
//   - Data-type constants for common DSI packets
//   - Default long-packet data-type mask (bit n set: DT[3:0]==n is a long packet)
//   - Parser FSM state encoding
//   - CRC-16 constants (reflected CCITT polynomial, init value)
//   - dsi_ecc6: 6-bit Hamming ECC over the 24 header bits
package mipi_dsi_pkg;

  localparam logic [5:0] DT_DCS_SHORT_WR0 = 6'h05;
  localparam logic [5:0] DT_DCS_SHORT_WR1 = 6'h15;
  localparam logic [5:0] DT_DCS_LONG_WR   = 6'h39;
  localparam logic [5:0] DT_GEN_LONG_WR   = 6'h29;
  localparam logic [5:0] DT_PACKED_PIXEL  = 6'h0C;

  localparam logic [15:0] LONG_DT_MASK_DEFAULT = 16'h7200;

  localparam logic [15:0] CRC16_POLY_REFL = 16'h8408;
  localparam logic [15:0] CRC16_INIT      = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_HDR,
    ST_PAYLOAD,
    ST_CRC
  } dsi_state_e;

  // Each ECC bit is the parity of a fixed subset of the header bits.
  function automatic logic [5:0] dsi_ecc6(input logic [23:0] hdr);
    logic [5:0] e;
    e[0] = ^(hdr & 24'hF12CB7);
    e[1] = ^(hdr & 24'hF2555B);
    e[2] = ^(hdr & 24'h749A6D);
    e[3] = ^(hdr & 24'hB8E38E);
    e[4] = ^(hdr & 24'hDF03F0);
    e[5] = ^(hdr & 24'hEFFC00);
    return e;
  endfunction

endpackage

// File: rtl/dsi_crc16_x4.sv
// dsi_crc16_x4: combinational CRC-16 update over up to four bytes per cycle.
//   crc_in  : running CRC before this word
//   data    : four bytes, byte 0 in [7:0] is processed first
//   byte_en : contiguous low-byte enables (4'b0001 .. 4'b1111)
//   crc_out : running CRC after the enabled bytes
module dsi_crc16_x4
  import mipi_dsi_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [31:0] data,
  input  logic [3:0]  byte_en,
  output logic [15:0] crc_out
);

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC16_POLY_REFL) : (r >> 1);
    end
    return r;
  endfunction

  always_comb begin
    crc_out = crc_in;
    for (int k = 0; k < 4; k++) begin
      if (byte_en[k]) crc_out = crc_byte(crc_out, data[8*k +: 8]);
    end
  end

endmodule

// File: rtl/mipi_dsi_pkt_parser.sv
// mipi_dsi_pkt_parser: splits the 4-lane HS byte stream into DSI packets.
//   clkrx, rstn          : byte clock, async active-low reset
//   RxActiveHS, rx_valid : burst active, word valid
//   rx_data              : lane0 byte in [7:0] .. lane3 byte in [31:24]
//   periph_rx_cmd(_valid): {WC, DI} of every header, one-cycle pulse
//   periph_rx_payload*   : payload words, zero-filled past WC, last-word flag
//   ecc_err/crc_err/trunc_err : error pulses, data path unaffected
module mipi_dsi_pkt_parser
  import mipi_dsi_pkg::*;
#(
  parameter logic [15:0] LONG_DT_MASK = LONG_DT_MASK_DEFAULT
) (
  input  logic        clkrx,
  input  logic        rstn,
  input  logic        RxActiveHS,
  input  logic        rx_valid,
  input  logic [31:0] rx_data,
  output logic [23:0] periph_rx_cmd,
  output logic        periph_rx_cmd_valid,
  output logic [31:0] periph_rx_payload,
  output logic        periph_rx_payload_valid,
  output logic        periph_rx_payload_valid_last,
  output logic        ecc_err,
  output logic        crc_err,
  output logic        trunc_err
);

  dsi_state_e  state_p0, state_nx;
  logic [15:0] rem_p0, rem_nx;
  logic [15:0] crc_acc_p0, crc_acc_nx;
  logic [7:0]  crc_lo_p0, crc_lo_nx;
  logic        crc_lo_vld_p0, crc_lo_vld_nx;

  logic [23:0] cmd_nx;
  logic        cmd_vld_nx, ecc_err_nx;
  logic [31:0] pay_nx;
  logic        pay_vld_nx, pay_last_nx, crc_err_nx, trunc_nx;

  logic [3:0]  byte_en;
  logic [31:0] pay_mask;
  logic [15:0] crc_upd;
  logic        done_w;

  // A received CRC of zero means the transmitter did not compute one.
  function automatic logic crc_bad(input logic [15:0] calc, input logic [15:0] rxd);
    return (rxd != 16'h0000) && (rxd != calc);
  endfunction

  always_comb begin
    byte_en = 4'b0000;
    if (rem_p0 >= 16'd4) begin
      byte_en = 4'b1111;
    end else begin
      case (rem_p0[1:0])
        2'd3:    byte_en = 4'b0111;
        2'd2:    byte_en = 4'b0011;
        2'd1:    byte_en = 4'b0001;
        default: byte_en = 4'b0000;
      endcase
    end
  end

  assign pay_mask = {{8{byte_en[3]}}, {8{byte_en[2]}}, {8{byte_en[1]}}, {8{byte_en[0]}}};

  dsi_crc16_x4 u_crc (
    .crc_in  (crc_acc_p0),
    .data    (rx_data),
    .byte_en (byte_en),
    .crc_out (crc_upd)
  );

  // A word that completes the packet is honoured even if the burst ends with it.
  assign done_w = rx_valid &&
                  ((state_p0 == ST_CRC) || ((state_p0 == ST_PAYLOAD) && (rem_p0 <= 16'd2)));

  always_comb begin
    state_nx      = state_p0;
    rem_nx        = rem_p0;
    crc_acc_nx    = crc_acc_p0;
    crc_lo_nx     = crc_lo_p0;
    crc_lo_vld_nx = crc_lo_vld_p0;
    cmd_nx        = periph_rx_cmd;
    cmd_vld_nx    = 1'b0;
    ecc_err_nx    = 1'b0;
    pay_nx        = periph_rx_payload;
    pay_vld_nx    = 1'b0;
    pay_last_nx   = 1'b0;
    crc_err_nx    = 1'b0;
    trunc_nx      = 1'b0;

    if (!RxActiveHS && !done_w) begin
      trunc_nx = (state_p0 != ST_HDR);
      state_nx = ST_HDR;
      rem_nx   = 16'd0;
    end else if (rx_valid) begin
      case (state_p0)
        ST_HDR: begin
          cmd_nx        = rx_data[23:0];
          cmd_vld_nx    = 1'b1;
          ecc_err_nx    = (dsi_ecc6(rx_data[23:0]) != rx_data[29:24]);
          crc_acc_nx    = CRC16_INIT;
          crc_lo_vld_nx = 1'b0;
          if (LONG_DT_MASK[rx_data[3:0]]) begin
            rem_nx   = rx_data[23:8];
            state_nx = (rx_data[23:8] == 16'd0) ? ST_CRC : ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          pay_vld_nx = 1'b1;
          pay_nx     = rx_data & pay_mask;
          crc_acc_nx = crc_upd;
          if (rem_p0 <= 16'd4) begin
            pay_last_nx = 1'b1;
            rem_nx      = 16'd0;
            case (rem_p0[2:0])
              3'd1: begin
                crc_err_nx = crc_bad(crc_upd, rx_data[23:8]);
                state_nx   = ST_HDR;
              end
              3'd2: begin
                crc_err_nx = crc_bad(crc_upd, rx_data[31:16]);
                state_nx   = ST_HDR;
              end
              3'd3: begin
                crc_lo_nx     = rx_data[31:24];
                crc_lo_vld_nx = 1'b1;
                state_nx      = ST_CRC;
              end
              default: begin
                crc_lo_vld_nx = 1'b0;
                state_nx      = ST_CRC;
              end
            endcase
          end else begin
            rem_nx = rem_p0 - 16'd4;
          end
        end
        ST_CRC: begin
          state_nx   = ST_HDR;
          crc_err_nx = crc_lo_vld_p0 ? crc_bad(crc_acc_p0, {rx_data[7:0], crc_lo_p0})
                                     : crc_bad(crc_acc_p0, rx_data[15:0]);
        end
        default: state_nx = ST_HDR;
      endcase
    end
  end

  // ---- register stage: parser state and all outputs ----
  always_ff @(posedge clkrx or negedge rstn) begin
    if (!rstn) begin
      state_p0                     <= ST_HDR;
      rem_p0                       <= 16'd0;
      crc_acc_p0                   <= 16'd0;
      crc_lo_p0                    <= 8'd0;
      crc_lo_vld_p0                <= 1'b0;
      periph_rx_cmd                <= 24'd0;
      periph_rx_cmd_valid          <= 1'b0;
      periph_rx_payload            <= 32'd0;
      periph_rx_payload_valid      <= 1'b0;
      periph_rx_payload_valid_last <= 1'b0;
      ecc_err                      <= 1'b0;
      crc_err                      <= 1'b0;
      trunc_err                    <= 1'b0;
    end else begin
      state_p0                     <= state_nx;
      rem_p0                       <= rem_nx;
      crc_acc_p0                   <= crc_acc_nx;
      crc_lo_p0                    <= crc_lo_nx;
      crc_lo_vld_p0                <= crc_lo_vld_nx;
      periph_rx_cmd                <= cmd_nx;
      periph_rx_cmd_valid          <= cmd_vld_nx;
      periph_rx_payload            <= pay_nx;
      periph_rx_payload_valid      <= pay_vld_nx;
      periph_rx_payload_valid_last <= pay_last_nx;
      ecc_err                      <= ecc_err_nx;
      crc_err                      <= crc_err_nx;
      trunc_err                    <= trunc_nx;
    end
  end

endmodule
